// File: rtl/pc_stack_unit.sv
// Program counter with a parameterised hardware return-address stack.
// Feeds the fetch address to the memory address mux; supports nested JPL/RET.
module pc_stack_unit #(
   parameter int                   AddrWidth   = 16,
   parameter int                   StackDepth  = 4,
   parameter logic [AddrWidth-1:0] ResetVector = '0
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           PC_Rst,
   input  logic                           PC_Ld,
   input  logic                           PC_Inc,
   input  logic [1:0]                     PC_Src,
   input  logic                           STK_Ld,
   input  logic                           BRA_Src,
   input  logic [15:0]                    IR,
   input  logic [AddrWidth-1:0]           Src1Data,
   output logic [AddrWidth-1:0]           PC,
   output logic [AddrWidth-1:0]           TopOfStack,
   output logic [$clog2(StackDepth):0]    StkCount,
   output logic                           StkOvf,
   output logic                           StkUnf
);

   localparam int IW = $clog2(StackDepth);
   localparam int CW = IW + 1;

   logic [StackDepth-1:0][AddrWidth-1:0] stk;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        cnt_lo, top_idx, wr_idx;
   logic                 clr, push, pop, empty, full;
   logic                 wr_en, cnt_inc, cnt_dec, ovf_set, unf_set;
   logic [AddrWidth-1:0] top, bra_addr, pc_nxt;

   assign clr     = !Reset || !PC_Rst;
   assign push    = !STK_Ld;
   assign pop     = !PC_Ld && (PC_Src == 2'b01);
   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(StackDepth));
   assign cnt_lo  = cnt[IW-1:0];
   // Depth is a power of two, so cnt_lo-1 also wraps correctly when full.
   assign top_idx = cnt_lo - IW'(1);
   assign top     = empty ? '0 : stk[top_idx];

   // A push alongside a live pop replaces the popped entry in place.
   assign wr_idx  = (pop && !empty) ? top_idx : cnt_lo;
   assign wr_en   = push && (!full || pop);
   assign cnt_inc = push && ((!pop && !full) || (pop && empty));
   assign cnt_dec = pop && !push && !empty;
   assign ovf_set = push && !pop && full;
   assign unf_set = pop && empty;

   assign bra_addr = BRA_Src ? PC + {{(AddrWidth-10){IR[9]}}, IR[9:0]} : Src1Data;

   always_comb begin
      pc_nxt = PC;
      if (!PC_Ld) begin
         case (PC_Src)
            2'b00:   pc_nxt = bra_addr;
            2'b01:   pc_nxt = top;
            2'b10:   pc_nxt = Src1Data;
            default: pc_nxt = PC;
         endcase
      end else if (!PC_Inc) begin
         pc_nxt = PC + AddrWidth'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (clr) begin
         PC     <= ResetVector;
         cnt    <= '0;
         StkOvf <= 1'b0;
         StkUnf <= 1'b0;
      end else begin
         PC <= pc_nxt;
         if (cnt_inc)      cnt <= cnt + CW'(1);
         else if (cnt_dec) cnt <= cnt - CW'(1);
         if (ovf_set) StkOvf <= 1'b1;
         if (unf_set) StkUnf <= 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (clr)        stk         <= '0;
      else if (wr_en) stk[wr_idx] <= PC;
   end

   assign TopOfStack = top;
   assign StkCount   = cnt;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a behavioural model queues the expected
// state for every cycle, which is compared #1 after the edge.
module tb_pc_stack_unit;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] tos;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        Clk = 1'b0;
   logic        r_reset = 1'b0, pc_rst = 1'b1, pc_ld = 1'b1, pc_inc = 1'b1;
   logic [1:0]  pc_src = 2'b00;
   logic        stk_ld = 1'b1, bra_src = 1'b0;
   logic [15:0] ir = '0, src1 = '0;
   logic [15:0] pc, tos;
   logic [2:0]  cnt;
   logic        ovf, unf;

   int n_cmp = 0;
   int n_err = 0;
   exp_t sbq[$];

   logic [15:0] m_pc;
   logic [15:0] m_stk [DEPTH];
   int          m_cnt;
   logic        m_ovf, m_unf;

   pc_stack_unit #(.AddrWidth(16), .StackDepth(DEPTH), .ResetVector(16'h0000)) dut (
      .Clk(Clk), .Reset(r_reset), .PC_Rst(pc_rst), .PC_Ld(pc_ld), .PC_Inc(pc_inc),
      .PC_Src(pc_src), .STK_Ld(stk_ld), .BRA_Src(bra_src), .IR(ir), .Src1Data(src1),
      .PC(pc), .TopOfStack(tos), .StkCount(cnt), .StkOvf(ovf), .StkUnf(unf)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge, written from the block description.
   task automatic model_step();
      logic [15:0] old_pc;
      logic        mpush, mpop, mempty, mfull;
      if (!r_reset || !pc_rst) begin
         m_pc = 16'h0000; m_cnt = 0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
         return;
      end
      old_pc = m_pc;
      mempty = (m_cnt == 0);
      mfull  = (m_cnt == DEPTH);
      mpush  = !stk_ld;
      mpop   = !pc_ld && pc_src == 2'b01;
      if (!pc_ld) begin
         case (pc_src)
            2'b00: m_pc = bra_src ? old_pc + {{6{ir[9]}}, ir[9:0]} : src1;
            2'b01: m_pc = mempty ? 16'h0000 : m_stk[m_cnt-1];
            2'b10: m_pc = src1;
            default: m_pc = old_pc;
         endcase
      end else if (!pc_inc) m_pc = old_pc + 16'h1;
      if (mpush && mpop) begin
         if (!mempty) m_stk[m_cnt-1] = old_pc;
         else begin m_stk[0] = old_pc; m_cnt = 1; m_unf = 1; end
      end else if (mpush) begin
         if (mfull) m_ovf = 1;
         else begin m_stk[m_cnt] = old_pc; m_cnt++; end
      end else if (mpop) begin
         if (mempty) m_unf = 1;
         else m_cnt--;
      end
   endtask

   task automatic tick();
      exp_t e;
      model_step();
      e.pc  = m_pc;
      e.tos = (m_cnt > 0) ? m_stk[m_cnt-1] : 16'h0000;
      e.cnt = 3'(m_cnt);
      e.ovf = m_ovf;
      e.unf = m_unf;
      sbq.push_back(e);
      @(posedge Clk);
      #1;
      e = sbq.pop_front();
      chk("pc",  pc,  e.pc);
      chk("tos", tos, e.tos);
      chk("cnt", {13'h0, cnt}, {13'h0, e.cnt});
      chk("ovf", {15'h0, ovf}, {15'h0, e.ovf});
      chk("unf", {15'h0, unf}, {15'h0, e.unf});
      r_reset = 1; pc_rst = 1; pc_ld = 1; pc_inc = 1; stk_ld = 1;
   endtask

   task automatic load(input logic [15:0] v);
      pc_ld = 0; pc_src = 2'b10; src1 = v; tick();
   endtask

   task automatic pop_cyc();
      pc_ld = 0; pc_src = 2'b01; tick();
   endtask

   initial begin
      // 1: reset, then idle hold
      r_reset = 0; tick();
      r_reset = 0; tick();
      chk("rst_pc", pc, 16'h0000);
      repeat (5) tick();
      chk("idle_pc", pc, 16'h0000);

      // 2: increment, wrap, load beats increment
      load(16'h00FF); pc_inc = 0; tick();
      chk("inc_carry", pc, 16'h0100);
      load(16'hFFFF); pc_inc = 0; tick();
      chk("inc_wrap", pc, 16'h0000);
      pc_inc = 0; pc_ld = 0; pc_src = 2'b10; src1 = 16'h1234; tick();
      chk("ld_over_inc", pc, 16'h1234);

      // 3: relative and absolute branch
      load(16'h0010); pc_ld = 0; pc_src = 2'b00; bra_src = 1; ir = 16'h03FE; tick();
      chk("bra_rel_neg", pc, 16'h000E);
      pc_ld = 0; pc_src = 2'b00; bra_src = 0; src1 = 16'h0200; tick();
      chk("bra_abs", pc, 16'h0200);

      // 4: nested JPL / RET
      load(16'h0005);
      stk_ld = 0; pc_ld = 0; pc_src = 2'b10; src1 = 16'h0040; tick();
      chk("jpl1_tos", tos, 16'h0005);
      chk("jpl1_cnt", {13'h0, cnt}, 16'd1);
      pc_inc = 0; tick();
      stk_ld = 0; pc_ld = 0; pc_src = 2'b10; src1 = 16'h0080; tick();
      chk("jpl2_cnt", {13'h0, cnt}, 16'd2);
      pop_cyc(); chk("ret1_pc", pc, 16'h0041);
      pop_cyc(); chk("ret2_pc", pc, 16'h0005);
      chk("ret2_cnt", {13'h0, cnt}, 16'd0);

      // 5: overflow, then underflow, then flag clear
      pc_rst = 0; tick();
      repeat (5) begin stk_ld = 0; pc_inc = 0; tick(); end
      chk("ovf_cnt", {13'h0, cnt}, 16'd4);
      chk("ovf_flag", {15'h0, ovf}, 16'd1);
      pop_cyc(); chk("ovf_pop3", pc, 16'h0003);
      pop_cyc(); pop_cyc(); pop_cyc(); chk("ovf_pop0", pc, 16'h0000);
      pc_rst = 0; tick();
      load(16'h0077); pop_cyc();
      chk("unf_pc", pc, 16'h0000);
      chk("unf_flag", {15'h0, unf}, 16'd1);
      pc_rst = 0; tick();
      chk("clr_flags", {14'h0, ovf, unf}, 16'd0);

      // 6: Reset beats push+pop; push+pop swaps top
      load(16'h0011); stk_ld = 0; tick();
      load(16'h0022); stk_ld = 0; tick();
      r_reset = 0; stk_ld = 0; pc_ld = 0; pc_src = 2'b01; tick();
      chk("rst_mid_pc", pc, 16'h0000);
      chk("rst_mid_cnt", {13'h0, cnt}, 16'd0);
      load(16'h0011); stk_ld = 0; tick();
      load(16'h0033); stk_ld = 0; pc_ld = 0; pc_src = 2'b10; src1 = 16'h0050; tick();
      stk_ld = 0; pc_ld = 0; pc_src = 2'b01; tick();
      chk("swap_pc", pc, 16'h0033);
      chk("swap_tos", tos, 16'h0050);
      chk("swap_cnt", {13'h0, cnt}, 16'd2);
      pc_rst = 0; tick();
      load(16'h0009); stk_ld = 0; pc_ld = 0; pc_src = 2'b01; tick();
      chk("swap_empty_pc", pc, 16'h0000);
      chk("swap_empty_tos", tos, 16'h0009);
      chk("swap_empty_unf", {15'h0, unf}, 16'd1);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         r_reset = ($urandom_range(0, 63) != 0);
         pc_rst  = ($urandom_range(0, 31) != 0);
         pc_ld   = ($urandom_range(0, 2) != 0);
         pc_inc  = 1'($urandom);
         pc_src  = 2'($urandom);
         stk_ld  = ($urandom_range(0, 2) != 0);
         bra_src = 1'($urandom);
         ir      = 16'($urandom);
         src1    = 16'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Program-counter and return-address-stack datapath stage. It sits directly downstream of the sequence control matrix and consumes its PC_Rst, PC_Ld, PC_Inc, PC_Src, STK_Ld and BRA_Src strobes. It produces the fetch address that goes to the memory address mux. It replaces the single link register with a parameterised-depth hardware return stack, so nested JPL/RET sequences are supported.

Parameters:
AddrWidth, 16, width of PC, stack entries and address operands
StackDepth, 4, number of return-stack entries (power of two, >=2)
ResetVector, 0, value loaded into PC on Reset or PC_Rst

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-low; clock Clk
PC_Rst  input  1  active-low; reset PC and stack
PC_Ld  input  1  active-low; load PC from the source selected by PC_Src
PC_Inc  input  1  active-low; PC <= PC+1
PC_Src  input  2  00 branch address, 01 pop return stack, 10 Src1Data, 11 reserved
STK_Ld  input  1  active-low; push current PC onto return stack
BRA_Src  input  1  1: branch address = PC + sext(IR[9:0]); 0: branch address = Src1Data
IR  input  16  instruction register (offset field IR[9:0])
Src1Data  input  AddrWidth  register-file source-1 read data
PC  output  AddrWidth  current program counter (registered)
TopOfStack  output  AddrWidth  combinational view of the top entry (0 when empty)
StkCount  output  clog2(StackDepth)+1  number of valid entries
StkOvf  output  1  sticky: a push was attempted while full
StkUnf  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset==0 at posedge: PC=ResetVector, StkCount=0, StkOvf=0, StkUnf=0, all entries=0. Reset overrides all other inputs, including mid-operation.
- PC_Rst==0 (with Reset==1): same effect as Reset. Priority: Reset > PC_Rst > PC_Ld > PC_Inc.
- PC_Ld==0: PC updated on the next edge (1-cycle latency) per PC_Src.
  - 00: branch address per BRA_Src. Sext 10->AddrWidth; addition is modulo 2^AddrWidth. The PC value used is the registered PC at that edge, i.e. the already-incremented value.
  - 10: PC <= Src1Data.
  - 01: PC <= top entry; StkCount decrements.
  - 11: PC holds; no other effect.
- PC_Inc==0 and PC_Ld==1: PC <= PC+1, wrapping from all-ones to 0. If PC_Ld==0, PC_Inc is ignored.
- Push (STK_Ld==0, PC_Rst==1):
  - Writes the current registered PC into entry[StkCount] and increments StkCount.
  - Push value is the PC before any load on the same edge, i.e. the return address.
  - Full (StkCount==StackDepth): no write, count unchanged, StkOvf<=1. A PC load on the same edge still happens.
- Pop (PC_Ld==0 and PC_Src==01):
  - Empty: PC <= 0, StkUnf<=1, count unchanged.
- Simultaneous push and pop:
  - Non-empty: PC <= old top, top entry overwritten with old PC, count unchanged, no flags.
  - Empty: PC <= 0, StkUnf<=1, push proceeds (count 0->1).
- Sticky flags clear only on Reset or PC_Rst.
- TopOfStack = entry[StkCount-1] when StkCount>0, else 0.
- No state changes when all strobes are inactive (high).

Test Plan:
1. Hold Reset=0 for 2 cycles, then release with all strobes high: PC=0, StkCount=0, flags 0, and the PC holds for 5 cycles.
2. PC=0x00FF, PC_Inc=0 for 1 cycle -> PC=0x0100. From PC=0xFFFF, PC_Inc=0 -> PC=0x0000. Assert PC_Inc=0 and PC_Ld=0 with PC_Src=10, Src1Data=0x1234 together -> PC=0x1234.
3. PC=0x0010, PC_Ld=0, PC_Src=00, BRA_Src=1, IR[9:0]=0x3FE (-2) -> PC=0x000E. Repeat with BRA_Src=0, Src1Data=0x0200 -> PC=0x0200.
4. JPL chain: PC=0x0005, STK_Ld=0, PC_Ld=0, PC_Src=10, Src1Data=0x0040 -> PC=0x0040, TopOfStack=0x0005, StkCount=1. A second JPL from 0x0041 to 0x0080 -> StkCount=2. Two RETs (PC_Src=01) -> PC=0x0041, then 0x0005, StkCount=0, no flags.
5. Five pushes with StackDepth=4 -> StkCount=4, StkOvf=1, entries 0..3 unchanged by the fifth. One pop on an empty stack after PC_Rst -> PC=0, StkUnf=1. PC_Rst=0 -> both flags clear.
6. With StkCount=2, Reset=0 asserted in the same cycle as a push and a pop -> PC=ResetVector, StkCount=0, flags 0. Simultaneous push+pop with top=0x0033, PC=0x0050 -> PC=0x0033, top=0x0050, StkCount=2.
